// File: rtl/fir_pkg.sv
// Shared types and helpers for the transposed-form stream FIR.
package fir_pkg;

    localparam int DEF_X_W   = 18;
    localparam int DEF_C_W   = 18;
    localparam int DEF_ACC_W = 54;

    // Saturation works on a 64-bit view of the accumulator, so ACC_W must stay <= 64.
    localparam int SAT_W = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fir_state_t;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Arithmetic right shift, then clip to a signed out_w-bit range.
    function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] value,
                                           input int shift,
                                           input int out_w);
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t res;
        shifted = value >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        res.sat = 1'b0;
        res.val = shifted;
        if (out_w < SAT_W) begin
            if (shifted > hi) begin
                res.sat = 1'b1;
                res.val = hi;
            end else if (shifted < lo) begin
                res.sat = 1'b1;
                res.val = lo;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_stream_filter_tap.sv
// One transposed-form tap: z <= b*x + z_next on advance, cleared by flush.
module fir_tap
    import fir_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int C_W   = DEF_C_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [X_W-1:0]   x,
    input  logic signed [C_W-1:0]   b,
    input  logic signed [ACC_W-1:0] z_next,
    input  logic                    adv,
    input  logic                    clr,
    output logic signed [ACC_W-1:0] z
);

    localparam int P_W = X_W + C_W;

    logic signed [P_W-1:0] prod;

    assign prod = P_W'(x) * P_W'(b);

    // Chain register: hold on stall, wrap at ACC_W on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= '0;
        end else if (clr) begin
            z <= '0;
        end else if (adv) begin
            z <= ACC_W'(prod) + z_next;
        end
    end

endmodule

// File: rtl/fir_stream_filter.sv
// Parametrised transposed FIR with double-buffered coefficients,
// valid/ready streaming, saturating output and flush.
//
// state    | meaning
// ST_EMPTY | output register holds no valid sample (m_valid=0)
// ST_FULL  | output register holds a sample waiting for the sink (m_valid=1)
module fir_stream_filter
    import fir_pkg::*;
#(
    parameter int N_TAPS    = 6,
    parameter int X_W       = DEF_X_W,
    parameter int C_W       = DEF_C_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = 54,
    parameter int OUT_SHIFT = 0,
    parameter int COEF_AW   = (N_TAPS > 2) ? $clog2(N_TAPS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [X_W-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_sat,
    input  logic                    coef_we,
    input  logic [COEF_AW-1:0]      coef_adr,
    input  logic signed [C_W-1:0]   coef_din,
    input  logic                    coef_commit,
    input  logic                    flush,
    output logic                    busy
);

    localparam int P_W = X_W + C_W;

    fir_state_t              state;
    logic                    accept;
    logic signed [C_W-1:0]   coef_sh  [N_TAPS];
    logic signed [C_W-1:0]   coef_act [N_TAPS];
    logic signed [ACC_W-1:0] z_chain  [1:N_TAPS];
    logic signed [P_W-1:0]   prod0;
    logic signed [ACC_W-1:0] y;
    sat_res_t                sat_r;

    assign s_ready = !flush && ((state == ST_EMPTY) || m_ready);
    assign accept  = s_valid && s_ready;
    assign m_valid = (state == ST_FULL);

    // Shadow writes and commit share an edge; the commit copies the pre-write shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_sh  <= '{default: '0};
            coef_act <= '{default: '0};
        end else begin
            if (coef_we && (int'(coef_adr) < N_TAPS)) begin
                coef_sh[coef_adr] <= coef_din;
            end
            if (coef_commit) begin
                coef_act <= coef_sh;
            end
        end
    end

    assign z_chain[N_TAPS] = '0;

    for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
        fir_tap #(
            .X_W   (X_W),
            .C_W   (C_W),
            .ACC_W (ACC_W)
        ) u_tap (
            .clk    (clk),
            .rst_n  (rst_n),
            .x      (s_data),
            .b      (coef_act[k]),
            .z_next (z_chain[k+1]),
            .adv    (accept),
            .clr    (flush),
            .z      (z_chain[k])
        );
    end

    // Tap 0 feeds the output register directly.
    assign prod0 = P_W'(s_data) * P_W'(coef_act[0]);
    assign y     = ACC_W'(prod0) + z_chain[1];
    assign sat_r = sat_shift(SAT_W'(y), OUT_SHIFT, OUT_W);

    // Output register FSM: capture on accept, drop on drain without a refill, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            m_data <= '0;
            m_sat  <= 1'b0;
            busy   <= 1'b0;
        end else if (flush) begin
            state <= ST_EMPTY;
            m_sat <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_FULL;
                ST_FULL:  if (m_ready && !accept) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
            if (accept) begin
                m_data <= OUT_W'(sat_r.val);
                m_sat  <= sat_r.sat;
                busy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_filter.sv
// Directed bench for fir_stream_filter: default instance plus a 16-bit-output
// instance for saturation, both driven from the same stimulus.
module tb_fir_stream_filter;

    logic               clk;
    logic               rst_n;
    logic               s_valid;
    logic signed [17:0] s_data;
    logic               m_ready;
    logic               coef_we;
    logic [2:0]         coef_adr;
    logic signed [17:0] coef_din;
    logic               coef_commit;
    logic               flush;

    logic               s_ready,  m_valid,  m_sat,  busy;
    logic signed [53:0] m_data;
    logic               s_ready2, m_valid2, m_sat2, busy2;
    logic signed [15:0] m_data2;

    int checks = 0;
    int errors = 0;
    int h [6] = '{200, 152, 48, -30, -37, 0};

    fir_stream_filter dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .coef_we(coef_we), .coef_adr(coef_adr), .coef_din(coef_din),
        .coef_commit(coef_commit), .flush(flush), .busy(busy)
    );

    fir_stream_filter #(.OUT_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_sat(m_sat2),
        .coef_we(coef_we), .coef_adr(coef_adr), .coef_din(coef_din),
        .coef_commit(coef_commit), .flush(flush), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int adr, input int val);
        coef_we  = 1'b1;
        coef_adr = 3'(adr);
        coef_din = 18'(val);
        cyc();
        coef_we  = 1'b0;
    endtask

    task automatic commit_bank();
        coef_commit = 1'b1;
        cyc();
        coef_commit = 1'b0;
    endtask

    task automatic run_impulse(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0) ? 18'sd1 : 18'sd0;
            #1;
            chk({tag, "_s_ready"}, s_ready, 1);
            cyc();
            chk({tag, "_m_valid"}, m_valid, 1);
            chk({tag, "_m_data"}, m_data, h[i]);
            chk({tag, "_m_sat"}, m_sat, 0);
        end
        s_valid = 1'b0;
        cyc();
        chk({tag, "_drained"}, m_valid, 0);
    endtask

    initial begin
        int  i_src, j_snk;
        bit  full, acc, drain, hold;
        logic signed [53:0] held;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        coef_we = 1'b0; coef_adr = '0; coef_din = '0; coef_commit = 1'b0; flush = 1'b0;
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sat", m_sat, 0);
        chk("rst_busy", busy, 0);
        #5 rst_n = 1'b1;
        cyc();

        // Impulse response with free-flowing sink
        for (int k = 0; k < 6; k++) wr_coef(k, h[k]);
        commit_bank();
        chk("pre_busy", busy, 0);
        run_impulse("imp");
        chk("imp_busy", busy, 1);

        // Backpressure: sink ready on every third cycle
        i_src = 0; j_snk = 0; full = 1'b0;
        for (int c = 0; c < 40 && j_snk < 6; c++) begin
            m_ready = (c % 3 == 0);
            s_valid = (i_src < 6);
            s_data  = (i_src == 0) ? 18'sd1 : 18'sd0;
            #1;
            chk("bp_m_valid", m_valid, full);
            chk("bp_s_ready", s_ready, !full || m_ready);
            drain = full && m_ready;
            acc   = s_valid && (!full || m_ready);
            hold  = full && !m_ready;
            held  = m_data;
            if (drain) begin
                chk("bp_m_data", m_data, h[j_snk]);
                j_snk++;
            end
            cyc();
            if (hold) chk("bp_hold", m_data, held);
            if (acc) i_src++;
            full = acc ? 1'b1 : (drain ? 1'b0 : full);
        end
        chk("bp_count", j_snk, 6);
        s_valid = 1'b0;

        // Flush while the output is stalled and a sample is offered
        m_ready = 1'b0; s_valid = 1'b1; s_data = 18'sd3;
        cyc();
        chk("fl_pre_valid", m_valid, 1);
        chk("fl_pre_data", m_data, 600);
        flush = 1'b1;
        #1;
        chk("fl_s_ready", s_ready, 0);
        cyc();
        flush = 1'b0; s_valid = 1'b0;
        chk("fl_m_valid", m_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_m_sat", m_sat, 0);
        run_impulse("fl_imp");

        // Commit in the same cycle as an accept
        wr_coef(0, 7);
        for (int k = 1; k < 6; k++) wr_coef(k, 0);
        commit_bank();
        wr_coef(0, 1000);
        m_ready = 1'b1; s_valid = 1'b1; s_data = 18'sd1;
        cyc();
        chk("cm_shadow_only", m_data, 7);
        coef_commit = 1'b1;
        cyc();
        coef_commit = 1'b0;
        chk("cm_old_bank", m_data, 7);
        cyc();
        chk("cm_new_bank", m_data, 1000);
        s_valid = 1'b0;
        cyc();

        // Write and commit on the same edge; out-of-range address ignored
        wr_coef(0, 5);
        coef_we = 1'b1; coef_adr = 3'd0; coef_din = 18'sd9; coef_commit = 1'b1;
        cyc();
        coef_we = 1'b0; coef_commit = 1'b0;
        wr_coef(6, 77);
        s_valid = 1'b1; s_data = 18'sd1;
        cyc();
        chk("wc_pre_write", m_data, 5);
        s_valid = 1'b0;
        commit_bank();
        s_valid = 1'b1; s_data = 18'sd1;
        cyc();
        chk("wc_second_commit", m_data, 9);
        s_data = 18'sd0;
        cyc();
        chk("wc_tail", m_data, 0);
        s_valid = 1'b0;
        cyc();

        // Asynchronous reset mid-stream
        m_ready = 1'b0; s_valid = 1'b1; s_data = 18'sd1;
        cyc();
        chk("ar_pre_valid", m_valid, 1);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_m_valid", m_valid, 0);
        chk("ar_m_data", m_data, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1; s_valid = 1'b1; s_data = 18'sd5;
        cyc();
        chk("ar_post_valid", m_valid, 1);
        chk("ar_post_data", m_data, 0);
        s_valid = 1'b0;
        cyc();

        // Saturation on the 16-bit output instance
        for (int k = 0; k < 6; k++) wr_coef(k, 32767);
        commit_bank();
        s_valid = 1'b1; s_data = 18'sd32767;
        cyc();
        chk("sat_pos_valid", m_valid2, 1);
        chk("sat_pos_data", m_data2, 32767);
        chk("sat_pos_flag", m_sat2, 1);
        cyc();
        chk("sat_pos2_data", m_data2, 32767);
        chk("sat_pos2_flag", m_sat2, 1);
        s_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("sat_flush_flag", m_sat2, 0);
        s_valid = 1'b1; s_data = -18'sd32768;
        cyc();
        chk("sat_neg_data", m_data2, -32768);
        chk("sat_neg_flag", m_sat2, 1);
        s_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        s_valid = 1'b1; s_data = 18'sd1;
        cyc();
        chk("sat_edge_data", m_data2, 32767);
        chk("sat_edge_flag", m_sat2, 0);
        s_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_stream_filter.md
Name: fir_stream_filter

Overview:
- Parametrised transposed-form FIR, successor to the fixed 6-tap sinc filter top.
- Taps, widths and output scaling are parameters.
- Coefficients are run-time loadable through a double-buffered (shadow/active) bank; samples flow over valid/ready handshakes with backpressure, saturating output and a flush command.
- Sits between the sample source (memory reader or ADC front end) and the downstream sink.

Parameters:
N_TAPS, 6, number of taps (>=2)
X_W, 18, signed sample width
C_W, 18, signed coefficient width
ACC_W, 54, signed accumulator/chain width; two's-complement wrap inside chain
OUT_W, 54, signed output width (<= ACC_W)
OUT_SHIFT, 0, arithmetic right shift applied before saturation
COEF_AW, clog2(N_TAPS) (min 1), coefficient address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
s_valid  in  1  input sample valid
s_ready  out  1  filter can accept sample
s_data  in  X_W  signed input sample
m_valid  out  1  output sample valid
m_ready  in  1  sink accepts output
m_data  out  OUT_W  signed filtered output
m_sat  out  1  m_data was saturated (qualified by m_valid)
coef_we  in  1  write shadow coefficient
coef_adr  in  COEF_AW  shadow coefficient index
coef_din  in  C_W  signed coefficient value
coef_commit  in  1  copy shadow bank to active bank
flush  in  1  clear delay line and drop pending output
busy  out  1  delay line holds non-flushed history

Behaviour:
- Reset (rst_n low, async): m_valid=0, m_data=0, m_sat=0, busy=0; all chain registers, shadow and active coefficients = 0.
- Handshake: s_ready = !flush && (!m_valid || m_ready), combinational. Accept = s_valid && s_ready. Output register drains on m_valid && m_ready.
- Advance only on accept; no chain or output change otherwise (stall holds state exactly).
- Arithmetic, on accept with active bank b[k]:
  - y = b[0]*x + z[1]
  - z[k] <= b[k]*x + z[k+1] for 1<=k<N_TAPS-1
  - z[N_TAPS-1] <= b[N_TAPS-1]*x
  - Products sign-extended to ACC_W; sums wrap at ACC_W.
- Output, latency 1: m_data/m_sat registered on the accept edge; m_valid set next cycle.
  - Output value: y >>> OUT_SHIFT, saturated to OUT_W (max 2^(OUT_W-1)-1, min -2^(OUT_W-1)); m_sat=1 when clipped.
  - m_data holds stable while m_valid && !m_ready.
  - Simultaneous drain and accept: new sample replaces old, m_valid stays 1 (full throughput, one sample/cycle).
- Coefficients:
  - coef_we writes shadow[coef_adr]; coef_adr >= N_TAPS ignored.
  - coef_commit copies the whole shadow bank to the active bank on that edge.
  - Write and commit in the same cycle: commit copies the shadow contents before the write; the write lands in shadow only.
  - Accept in the same cycle as commit: that sample uses the old active bank; the new bank applies from the next accepted sample.
  - Writes never disturb the active bank or in-flight data.
- Flush:
  - Sample is not accepted that cycle (s_ready=0).
  - On that edge: z[*]=0, m_valid=0 (pending output dropped), m_sat=0, busy=0.
  - Coefficients unaffected.
  - Flush with commit: both take effect.
- busy: set on any accept; cleared only by flush or reset.
- State machine: EMPTY (m_valid=0) / FULL (m_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain without accept.
  - Any->EMPTY on flush.
- Reset mid-stream: immediate async clear; the first accept after rst_n rises sees zero history.

Decomposition:
- Package fir_pkg:
  - default widths (X_W/C_W/ACC_W = 18/18/54)
  - saturation function sat_shift(value, shift, out_w)
  - EMPTY/FULL state encoding
- Sub-module fir_tap: one transposed tap.
  - Inputs: x, b, z_next, adv, clr.
  - Function: registered multiply-add, instantiated N_TAPS-1 times by generate; tap 0 combinational into the output register.

Test Plan:
- Load shadow 200,152,48,-30,-37,0, commit. Send impulse 1 then five 0s with m_ready=1 -> m_data 200,152,48,-30,-37,0, one per cycle, latency 1, m_sat=0.
- Backpressure: same stream, m_ready toggled 1,0,0,1,... -> s_ready low while output held; sequence identical, no loss or duplication; m_data stable during stall.
- Saturation: OUT_W=16, all b=32767, step x=32767 -> m_data=32767 with m_sat=1 from the first output; x=-32768 -> -32768, m_sat=1.
- Commit mid-stream: constant x=1; commit b[0]=1000 (others 0) in the same cycle as an accept -> that output still uses the old bank; the next output = 1000.
- Write and commit same cycle at adr 0 (shadow old 5, write 9) -> active b[0]=5; a second commit yields 9. coef_adr=N_TAPS is ignored.
- Flush with m_valid=1, m_ready=0, s_valid=1 -> sample not accepted, m_valid=0, busy=0. Next impulse reproduces the clean impulse response. Async rst_n pulse mid-stream clears all outputs immediately.
